// File: rtl/cpu_trace_defs.sv
// Shared definitions for the retirement-trace recorder: FSM state codes and
// the packed entry-width helper.
package cpu_trace_defs;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_POST  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_ARMED = ST_ARMED,
    S_POST  = ST_POST,
    S_DONE  = ST_DONE
  } trace_state_e;

  function automatic int entry_w(int pc_w, int instr_w, int data_w);
    return pc_w + instr_w + data_w;
  endfunction

endpackage

// File: rtl/trace_ram.sv
// DEPTH x W trace storage: one synchronous write port, one registered read
// port whose output register resets to zero and holds when not reading.
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int W     = 96,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rdata_d, rdata_q;

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[raddr];
  end

  always_ff @(posedge clock) begin
    if (reset) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/cpu_trace_buffer.sv
// Retirement-trace recorder: circular capture of {pc, instr, wd}, freeze a
// programmable number of entries after a trigger, then random-access readout.
module cpu_trace_buffer
  import cpu_trace_defs::*;
#(
  parameter int PC_W      = 32,
  parameter int INSTR_W   = 32,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 8,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               arm,
  input  logic               force_trig,
  input  logic [PC_W-1:0]    trig_pc,
  input  logic               trig_pc_en,
  input  logic               valid_in,
  input  logic [PC_W-1:0]    pc_in,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [DATA_W-1:0]  wd_in,
  input  logic [AW-1:0]      rd_addr,
  output logic [PC_W-1:0]    rd_pc,
  output logic [INSTR_W-1:0] rd_instr,
  output logic [DATA_W-1:0]  rd_wd,
  output logic               rd_valid,
  output logic [AW:0]        count,
  output logic [1:0]         state,
  output logic               done
);

  localparam int ENTRY_W = entry_w(PC_W, INSTR_W, DATA_W);

  trace_state_e  state_d, state_q;
  logic [AW-1:0] wr_ptr_d, wr_ptr_q;
  logic [AW:0]   count_d, count_q;
  logic [AW-1:0] post_cnt_d, post_cnt_q;
  logic          rd_valid_d, rd_valid_q;

  logic               we, pc_hit, rd_en;
  logic [AW-1:0]      raddr;
  logic [ENTRY_W-1:0] rdata;

  assign pc_hit = valid_in & trig_pc_en & (pc_in == trig_pc);

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    post_cnt_d = post_cnt_q;
    we         = 1'b0;
    // arm restarts from any state and swallows same-cycle capture/trigger
    if (arm) begin
      state_d    = S_ARMED;
      wr_ptr_d   = '0;
      count_d    = '0;
      post_cnt_d = '0;
    end else begin
      unique case (state_q)
        S_ARMED: begin
          we = valid_in;
          if (pc_hit || force_trig) begin
            if (POST_TRIG == 0) state_d = S_DONE;
            else begin
              post_cnt_d = AW'(POST_TRIG);
              state_d    = S_POST;
            end
          end
        end
        S_POST: begin
          we = valid_in;
          if (valid_in) begin
            post_cnt_d = post_cnt_q - AW'(1);
            if (post_cnt_q == AW'(1)) state_d = S_DONE;
          end
        end
        default: ;
      endcase
      if (we) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
        if (count_q != (AW+1)'(DEPTH)) count_d = count_q + (AW+1)'(1);
      end
    end
  end

  // Index 0 is the oldest entry; count[AW-1:0] is 0 when full, so oldest = wr_ptr.
  assign raddr      = wr_ptr_q - count_q[AW-1:0] + rd_addr;
  assign rd_en      = (state_q == S_DONE) && ({1'b0, rd_addr} < count_q);
  assign rd_valid_d = rd_en;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      post_cnt_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      post_cnt_q <= post_cnt_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  trace_ram #(.DEPTH(DEPTH), .W(ENTRY_W)) u_ram (
    .clock (clock),
    .reset (reset),
    .we    (we),
    .waddr (wr_ptr_q),
    .wdata ({pc_in, instr_in, wd_in}),
    .re    (rd_en),
    .raddr (raddr),
    .rdata (rdata)
  );

  assign {rd_pc, rd_instr, rd_wd} = rdata;
  assign rd_valid = rd_valid_q;
  assign count    = count_q;
  assign state    = state_q;
  assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Bench for cpu_trace_buffer: two instances (POST_TRIG=8 and 0) share inputs
// and are compared against a queue-based model of the captured trace.
module tb_cpu_trace_buffer;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int PT0   = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        arm = 1'b0, force_trig = 1'b0, trig_pc_en = 1'b0, valid_in = 1'b0;
  logic [31:0] trig_pc = '0, pc_in = '0, instr_in = '0, wd_in = '0;
  logic [AW-1:0] rd_addr = '0;

  logic [31:0] rd_pc0, rd_instr0, rd_wd0, rd_pc1, rd_instr1, rd_wd1;
  logic        rd_valid0, rd_valid1, done0, done1;
  logic [AW:0] count0, count1;
  logic [1:0]  state0, state1;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  cpu_trace_buffer #(.DEPTH(DEPTH), .POST_TRIG(PT0)) dut0 (
    .clock(clock), .reset(reset), .arm(arm), .force_trig(force_trig),
    .trig_pc(trig_pc), .trig_pc_en(trig_pc_en), .valid_in(valid_in),
    .pc_in(pc_in), .instr_in(instr_in), .wd_in(wd_in), .rd_addr(rd_addr),
    .rd_pc(rd_pc0), .rd_instr(rd_instr0), .rd_wd(rd_wd0), .rd_valid(rd_valid0),
    .count(count0), .state(state0), .done(done0));

  cpu_trace_buffer #(.DEPTH(DEPTH), .POST_TRIG(0)) dut1 (
    .clock(clock), .reset(reset), .arm(arm), .force_trig(force_trig),
    .trig_pc(trig_pc), .trig_pc_en(trig_pc_en), .valid_in(valid_in),
    .pc_in(pc_in), .instr_in(instr_in), .wd_in(wd_in), .rd_addr(rd_addr),
    .rd_pc(rd_pc1), .rd_instr(rd_instr1), .rd_wd(rd_wd1), .rd_valid(rd_valid1),
    .count(count1), .state(state1), .done(done1));

  // Model: a queue of the most recent DEPTH captured entries per instance,
  // index 0 oldest; states numbered 0 idle, 1 armed, 2 post, 3 done.
  logic [95:0] mq0[$];
  logic [95:0] mq1[$];
  int          ms[2];
  int          mpost[2];
  logic        exp_rv[2];
  logic [95:0] exp_rd[2];

  function automatic int qsize(int k);
    return (k == 0) ? mq0.size() : mq1.size();
  endfunction

  function automatic logic [95:0] qget(int k, int i);
    return (k == 0) ? mq0[i] : mq1[i];
  endfunction

  task automatic qpush(int k, logic [95:0] e);
    if (k == 0) begin
      mq0.push_back(e);
      if (mq0.size() > DEPTH) void'(mq0.pop_front());
    end else begin
      mq1.push_back(e);
      if (mq1.size() > DEPTH) void'(mq1.pop_front());
    end
  endtask

  task automatic qclear(int k);
    if (k == 0) mq0.delete();
    else        mq1.delete();
  endtask

  // Advance both models using the inputs currently driven, then clock.
  task automatic tick();
    for (int k = 0; k < 2; k++) begin
      int  pt;
      logic hit;
      pt  = (k == 0) ? PT0 : 0;
      hit = valid_in && trig_pc_en && (pc_in == trig_pc);
      if (reset) begin
        exp_rv[k] = 1'b0; exp_rd[k] = '0;
      end else if (ms[k] == 3 && int'(rd_addr) < qsize(k)) begin
        exp_rv[k] = 1'b1; exp_rd[k] = qget(k, int'(rd_addr));
      end else begin
        exp_rv[k] = 1'b0;
      end
      if (reset) begin
        ms[k] = 0; mpost[k] = 0; qclear(k);
      end else if (arm) begin
        ms[k] = 1; mpost[k] = 0; qclear(k);
      end else if (ms[k] == 1) begin
        if (valid_in) qpush(k, {pc_in, instr_in, wd_in});
        if (hit || force_trig) begin
          if (pt == 0) ms[k] = 3;
          else begin mpost[k] = pt; ms[k] = 2; end
        end
      end else if (ms[k] == 2 && valid_in) begin
        qpush(k, {pc_in, instr_in, wd_in});
        mpost[k]--;
        if (mpost[k] == 0) ms[k] = 3;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic retire(input logic [31:0] pc);
    valid_in = 1'b1; pc_in = pc; instr_in = $urandom; wd_in = $urandom;
    tick();
    valid_in = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    tests++;
    if ({state0, count0, done0, rd_valid0, rd_pc0, rd_instr0, rd_wd0} !== '0) begin
      fails++;
      $display("FAIL reset_state: state=%0d count=%0d done=%0b rd_valid=%0b rd_pc=%0h required all zero",
               state0, count0, done0, rd_valid0, rd_pc0);
    end
    reset = 1'b0;
    for (int i = 0; i < 6; i++) retire(32'(i));
    tick();
    tests++;
    if (state0 !== 2'd0 || count0 !== '0 || rd_valid0 !== 1'b0) begin
      fails++;
      $display("FAIL idle_no_capture: state=%0d count=%0d rd_valid=%0b required 0/0/0",
               state0, count0, rd_valid0);
    end
  endtask

  task automatic test_pc_trigger();
    int budget;
    trig_pc = 32'd20; trig_pc_en = 1'b1; arm = 1'b1;
    tick(); arm = 1'b0;
    budget = 0;
    for (int pc = 0; ms[0] != 3 && budget < 40; pc += 4) begin
      retire(32'(pc)); budget++;
    end
    tests++;
    if (state0 !== 2'd3 || done0 !== 1'b1 || count0 !== 5'd14) begin
      fails++;
      $display("FAIL pctrig_done: state=%0d done=%0b count=%0d required 3/1/14", state0, done0, count0);
    end
    tests++;
    if (state1 !== 2'd3 || count1 !== 5'd6) begin
      fails++;
      $display("FAIL pctrig_post0: state=%0d count=%0d required 3/6", state1, count1);
    end
    retire(32'd56);
    tests++;
    if (count0 !== 5'd14) begin
      fails++;
      $display("FAIL done_frozen: count=%0d required 14", count0);
    end
    rd_addr = 4'd0; tick();
    tests++;
    if (rd_valid0 !== 1'b1 || rd_pc0 !== 32'd0 || {rd_pc0, rd_instr0, rd_wd0} !== exp_rd[0]) begin
      fails++;
      $display("FAIL pctrig_rd0: rd_valid=%0b rd_pc=%0h required 1/0", rd_valid0, rd_pc0);
    end
    rd_addr = 4'd13; tick();
    tests++;
    if (rd_valid0 !== 1'b1 || rd_pc0 !== 32'd52 || {rd_pc0, rd_instr0, rd_wd0} !== exp_rd[0]) begin
      fails++;
      $display("FAIL pctrig_rd13: rd_valid=%0b rd_pc=%0h required 1/34", rd_valid0, rd_pc0);
    end
    rd_addr = 4'd14; tick();
    tests++;
    if (rd_valid0 !== 1'b0 || rd_pc0 !== 32'd52) begin
      fails++;
      $display("FAIL rd_out_of_range: rd_valid=%0b rd_pc=%0h required 0/34 held", rd_valid0, rd_pc0);
    end
  endtask

  task automatic test_wrap();
    int budget;
    trig_pc = 32'd200; trig_pc_en = 1'b1; arm = 1'b1;
    tick(); arm = 1'b0;
    budget = 0;
    for (int pc = 0; ms[0] != 3 && budget < 80; pc += 4) begin
      retire(32'(pc)); budget++;
    end
    tests++;
    if (state0 !== 2'd3 || count0 !== 5'd16) begin
      fails++;
      $display("FAIL wrap_done: state=%0d count=%0d required 3/16", state0, count0);
    end
    rd_addr = 4'd0; tick();
    tests++;
    if (rd_valid0 !== 1'b1 || rd_pc0 !== 32'd172 || {rd_pc0, rd_instr0, rd_wd0} !== exp_rd[0]) begin
      fails++;
      $display("FAIL wrap_rd0: rd_valid=%0b rd_pc=%0d required 1/172", rd_valid0, rd_pc0);
    end
    rd_addr = 4'd15; tick();
    tests++;
    if (rd_valid0 !== 1'b1 || rd_pc0 !== 32'd232 || {rd_pc0, rd_instr0, rd_wd0} !== exp_rd[0]) begin
      fails++;
      $display("FAIL wrap_rd15: rd_valid=%0b rd_pc=%0d required 1/232", rd_valid0, rd_pc0);
    end
  endtask

  task automatic test_force_no_valid();
    trig_pc_en = 1'b0; arm = 1'b1;
    tick(); arm = 1'b0;
    for (int i = 0; i < 3; i++) retire($urandom);
    force_trig = 1'b1; valid_in = 1'b0;
    tick(); force_trig = 1'b0;
    tests++;
    if (state1 !== 2'd3 || done1 !== 1'b1 || count1 !== 5'd3) begin
      fails++;
      $display("FAIL force_post0: state=%0d done=%0b count=%0d required 3/1/3", state1, done1, count1);
    end
    tests++;
    if (state0 !== 2'd2 || count0 !== 5'd3) begin
      fails++;
      $display("FAIL force_post8: state=%0d count=%0d required 2/3", state0, count0);
    end
    rd_addr = 4'd2; tick();
    tests++;
    if (rd_valid1 !== 1'b1 || {rd_pc1, rd_instr1, rd_wd1} !== exp_rd[1]) begin
      fails++;
      $display("FAIL force_rd: rd_valid=%0b rd_pc=%0h required 1/%0h", rd_valid1, rd_pc1, exp_rd[1][95:64]);
    end
  endtask

  task automatic test_arm_in_post();
    trig_pc_en = 1'b0; arm = 1'b1;
    tick(); arm = 1'b0;
    retire($urandom); retire($urandom);
    force_trig = 1'b1; retire($urandom); force_trig = 1'b0;
    retire($urandom);
    tests++;
    if (state0 !== 2'd2 || count0 !== 5'd4) begin
      fails++;
      $display("FAIL pre_rearm: state=%0d count=%0d required 2/4", state0, count0);
    end
    arm = 1'b1; retire($urandom); arm = 1'b0;
    tests++;
    if (state0 !== 2'd1 || count0 !== 5'd0) begin
      fails++;
      $display("FAIL rearm_in_post: state=%0d count=%0d required 1/0", state0, count0);
    end
    tick();
    tests++;
    if (count0 !== 5'd0) begin
      fails++;
      $display("FAIL rearm_dropped_write: count=%0d required 0", count0);
    end
  endtask

  task automatic test_reset_in_post();
    arm = 1'b1; tick(); arm = 1'b0;
    force_trig = 1'b1; retire($urandom); force_trig = 1'b0;
    retire($urandom); retire($urandom);
    reset = 1'b1; tick(); reset = 1'b0;
    tests++;
    if (state0 !== 2'd0 || count0 !== '0 || done0 !== 1'b0 || rd_valid0 !== 1'b0 || rd_pc0 !== '0) begin
      fails++;
      $display("FAIL reset_in_post: state=%0d count=%0d done=%0b rd_valid=%0b required all 0",
               state0, count0, done0, rd_valid0);
    end
  endtask

  task automatic test_random();
    reset = 1'b1; tick(); reset = 1'b0;
    for (int c = 0; c < 600; c++) begin
      reset      = ($urandom_range(0, 199) == 0);
      arm        = ($urandom_range(0, 29) == 0);
      force_trig = ($urandom_range(0, 24) == 0);
      valid_in   = ($urandom_range(0, 9) < 7);
      trig_pc_en = ($urandom_range(0, 3) != 0);
      if (arm) trig_pc = 32'($urandom_range(0, 15) * 4);
      pc_in    = 32'($urandom_range(0, 15) * 4);
      instr_in = $urandom; wd_in = $urandom;
      rd_addr  = AW'($urandom_range(0, DEPTH - 1));
      tick();
      tests++;
      if (int'(state0) != ms[0] || int'(count0) != qsize(0) || done0 !== (ms[0] == 3) ||
          rd_valid0 !== exp_rv[0] || {rd_pc0, rd_instr0, rd_wd0} !== exp_rd[0]) begin
        fails++;
        $display("FAIL rand0 c=%0d: state=%0d count=%0d rv=%0b pc=%0h required %0d/%0d/%0b/%0h",
                 c, state0, count0, rd_valid0, rd_pc0, ms[0], qsize(0), exp_rv[0], exp_rd[0][95:64]);
      end
      tests++;
      if (int'(state1) != ms[1] || int'(count1) != qsize(1) || done1 !== (ms[1] == 3) ||
          rd_valid1 !== exp_rv[1] || {rd_pc1, rd_instr1, rd_wd1} !== exp_rd[1]) begin
        fails++;
        $display("FAIL rand1 c=%0d: state=%0d count=%0d rv=%0b pc=%0h required %0d/%0d/%0b/%0h",
                 c, state1, count1, rd_valid1, rd_pc1, ms[1], qsize(1), exp_rv[1], exp_rd[1][95:64]);
      end
    end
    reset = 1'b0; arm = 1'b0; force_trig = 1'b0; valid_in = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_pc_trigger();
    test_wrap();
    test_force_no_valid();
    test_arm_in_post();
    test_reset_in_post();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
